// File: rtl/img_stream_pkg.sv
// Shared types and default geometry for the image streaming blocks.
package img_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 512;
  localparam int DEF_IMG_H  = 512;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRIME     = 3'd1,
    S_SEND_WAIT = 3'd2,
    S_LINE      = 3'd3,
    S_PAD       = 3'd4,
    S_DRAIN     = 3'd5
  } state_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered output stage.
// Handshake: a beat moves on any rising edge where valid and ready are both high;
// valid, once raised, stays high with stable data until that beat moves (flush excepted).
module stream_skid_buffer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_in_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  input  logic         i_out_ready,
  output logic [1:0]   o_count
);

  logic [1:0]   r_count;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_pop;
  logic         w_push;

  assign w_pop       = (r_count != 2'd0) && i_out_ready;
  assign o_in_ready  = (r_count != 2'd2) || w_pop;
  assign w_push      = i_in_valid && o_in_ready;
  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = r_head;
  assign o_count     = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      // The head only moves on a pop or when it is empty, so it holds while stalled.
      case (r_count)
        2'd0: if (w_push) r_head <= i_in_data;
        2'd1: begin
          if (w_push && w_pop) r_head <= i_in_data;
          else if (w_push)     r_tail <= i_in_data;
        end
        2'd2: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) r_tail <= i_in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/line_burst_feeder.sv
// Frame source: primes a few lines from memory, then releases one line per interrupt
// credit, then appends zero lines, streaming everything through a skid buffer.
module line_burst_feeder
  import img_stream_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_W      = $clog2(IMG_W * IMG_H)
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ready,
  input  logic              i_intr,
  output state_e            o_dbg_state
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LINE_W = $clog2(IMG_H + 1);
  localparam int PAD_W  = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;
  localparam int CRED_W = $clog2(PRIME_LINES + 1);

  generate
    if (IMG_H < PRIME_LINES) begin : g_geom_check
      $error("line_burst_feeder: IMG_H must be >= PRIME_LINES");
    end
  endgenerate

  state_e              r_state;
  state_e              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [COL_W-1:0]    r_col;
  logic [LINE_W-1:0]   r_line;
  logic [PAD_W-1:0]    r_pad;
  logic [CRED_W-1:0]   r_credit;
  logic                r_intr_d;
  logic                r_inflight;
  logic                r_inflight_pad;
  logic                r_done;

  logic                w_intr_rise;
  logic                w_start_acc;
  logic                w_col_last;
  logic                w_issue;
  logic                w_space;
  logic                w_pop;
  logic [2:0]          w_fill;
  logic                w_empty;
  logic                w_line_end;
  logic                w_img_left;
  logic                w_pad_left;
  logic                w_credit_take;
  logic                w_done_set;

  logic                w_skid_in_ready;
  logic                w_skid_push;
  logic [DATA_W-1:0]   w_skid_din;
  logic                w_skid_valid;
  logic [DATA_W-1:0]   w_skid_dout;
  logic [1:0]          w_skid_count;

  assign w_intr_rise = i_intr && !r_intr_d;
  assign w_start_acc = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_col_last  = (r_col == COL_W'(IMG_W - 1));

  // A read is issued only if the buffer can take it once it lands, counting the
  // beat already in flight and the beat leaving this cycle.
  assign w_pop   = w_skid_valid && i_data_ready;
  assign w_fill  = {1'b0, w_skid_count} + {2'b0, r_inflight};
  assign w_space = (w_fill < (3'd2 + {2'b0, w_pop}));
  assign w_issue = ((r_state == S_PRIME) || (r_state == S_LINE) || (r_state == S_PAD))
                   && w_space && !i_abort;
  assign w_empty = (w_skid_count == 2'd0) && !r_inflight;

  always_comb begin
    w_next_state  = r_state;
    w_credit_take = 1'b0;
    w_done_set    = 1'b0;
    w_line_end    = 1'b0;
    w_img_left    = 1'b0;
    w_pad_left    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_PRIME;
      end
      S_PRIME, S_LINE: begin
        w_line_end = w_issue && w_col_last &&
                     ((r_state == S_LINE) || (r_line == LINE_W'(PRIME_LINES - 1)));
        w_img_left = ((r_line + 1'b1) < LINE_W'(IMG_H));
        w_pad_left = (PAD_LINES != 0);
      end
      S_PAD: begin
        w_line_end = w_issue && w_col_last;
        w_pad_left = ((r_pad + 1'b1) < PAD_W'(PAD_LINES));
      end
      S_SEND_WAIT: begin
        w_img_left = (r_line < LINE_W'(IMG_H));
        w_pad_left = (r_pad < PAD_W'(PAD_LINES));
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_next_state = S_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    // A line boundary with a credit already banked skips the wait state, so
    // credited lines follow each other without a bubble.
    if (w_line_end || (r_state == S_SEND_WAIT)) begin
      if (!w_img_left && !w_pad_left) begin
        w_next_state = S_DRAIN;
      end else if (r_credit != '0) begin
        w_credit_take = 1'b1;
        w_next_state  = w_img_left ? S_LINE : S_PAD;
      end else begin
        w_next_state = S_SEND_WAIT;
      end
    end

    if (i_abort) begin
      w_next_state  = S_IDLE;
      w_credit_take = 1'b0;
      w_done_set    = 1'b0;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state        <= S_IDLE;
      r_intr_d       <= 1'b0;
      r_done         <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_pad <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_intr_d       <= i_intr;
      r_done         <= w_done_set;
      r_inflight     <= w_issue;
      r_inflight_pad <= (r_state == S_PAD);
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_addr <= '0;
      r_col  <= '0;
      r_line <= '0;
      r_pad  <= '0;
    end else if (w_start_acc) begin
      r_addr <= '0;
      r_col  <= '0;
      r_line <= '0;
      r_pad  <= '0;
    end else if (w_issue) begin
      if (r_state != S_PAD) r_addr <= r_addr + 1'b1;
      if (w_col_last) begin
        r_col <= '0;
        if (r_state == S_PAD) r_pad <= r_pad + 1'b1;
        else                  r_line <= r_line + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_credit <= '0;
    end else if (w_start_acc) begin
      r_credit <= '0;
    end else if (w_intr_rise && !w_credit_take) begin
      if (r_credit != CRED_W'(PRIME_LINES)) r_credit <= r_credit + 1'b1;
    end else if (!w_intr_rise && w_credit_take) begin
      r_credit <= r_credit - 1'b1;
    end
  end

  assign w_skid_push = r_inflight && w_skid_in_ready;
  assign w_skid_din  = r_inflight_pad ? '0 : i_rd_data;

  stream_skid_buffer #(.W(DATA_W)) u_skid (
    .i_clk       (axi_clk),
    .i_rst_n     (axi_reset_n),
    .i_flush     (i_abort),
    .i_in_valid  (w_skid_push),
    .i_in_data   (w_skid_din),
    .o_in_ready  (w_skid_in_ready),
    .o_out_valid (w_skid_valid),
    .o_out_data  (w_skid_dout),
    .i_out_ready (i_data_ready),
    .o_count     (w_skid_count)
  );

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_rd_en      = w_issue && (r_state != S_PAD);
  assign o_rd_addr    = r_addr;
  assign o_data_valid = w_skid_valid;
  assign o_data       = w_skid_dout;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_line_burst_feeder.sv
// Bench for line_burst_feeder on an 8x6 image with mem[a] = a.
module tb_line_burst_feeder;
  import img_stream_pkg::*;

  localparam int DATA_W      = 8;
  localparam int IMG_W       = 8;
  localparam int IMG_H       = 6;
  localparam int PRIME_LINES = 4;
  localparam int PAD_LINES   = 2;
  localparam int ADDR_W      = $clog2(IMG_W * IMG_H);
  localparam int FRAME_PIX   = (IMG_H + PAD_LINES) * IMG_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              o_data_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_data_ready = 1'b1;
  logic              i_intr = 1'b0;
  state_e            dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int xfer_cyc[0:127];
  logic rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_abort = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [DATA_W-1:0] exp_q[$];

  line_burst_feeder #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .PRIME_LINES(PRIME_LINES), .PAD_LINES(PAD_LINES)
  ) dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (rd_data),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .i_data_ready (i_data_ready),
    .i_intr       (i_intr),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (o_rd_en) rd_data <= DATA_W'(o_rd_addr);

  always @(posedge clk) begin
    #1;
    i_data_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick(1);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic pulse_intr();
    tick(1);
    i_intr = 1'b1;
    tick(1);
    i_intr = 1'b0;
  endtask

  // Reference frame: every image pixel in raster order, then the zero pad lines.
  task automatic push_frame();
    for (int a = 0; a < IMG_W * IMG_H; a++) exp_q.push_back(DATA_W'(a));
    for (int p = 0; p < PAD_LINES * IMG_W; p++) exp_q.push_back('0);
  endtask

  task automatic begin_frame();
    push_frame();
    xfer_cnt = 0;
    pulse_start();
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int k = 0;
    while (xfer_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, (xfer_cnt >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, (done_cnt >= n), 1);
  endtask

  task automatic intr_burst(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      pulse_intr();
      tick(gap);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        check("hold_valid", o_data_valid, 1);
        check("hold_data", o_data, prev_data);
      end
      if (o_data_valid && i_data_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", o_data_valid, 0);
        end else begin
          check("pixel", o_data, exp_q.pop_front());
        end
        if (xfer_cnt < 128) xfer_cyc[xfer_cnt] = cyc;
        xfer_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        check("busy_falls_with_done", o_busy, 0);
      end
      prev_stall = o_data_valid && !i_data_ready;
      prev_abort = i_abort;
      prev_data  = o_data;
    end
  end

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_valid", o_data_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rd_en", o_rd_en, 0);
    check("rst_data", o_data, 0);
    check("rst_addr", o_rd_addr, 0);

    // Prime only: 32 contiguous pixels, then stall waiting for credit.
    d0 = done_cnt;
    begin_frame();
    tick(5);
    pulse_start();  // must be ignored while busy
    wait_xfers(32, 200, "prime_timeout");
    tick(10);
    @(negedge clk);
    check("prime_count", xfer_cnt, 32);
    check("prime_valid_low", o_data_valid, 0);
    check("prime_busy", o_busy, 1);
    check("prime_no_gap", xfer_cyc[31] - xfer_cyc[0], 31);

    // Credits release remaining lines and pad lines.
    intr_burst(4, IMG_W + 4);
    wait_done(d0 + 1, 300, "frame1_done_timeout");
    tick(5);
    check("frame1_total", xfer_cnt, FRAME_PIX);
    check("frame1_done_once", done_cnt, d0 + 1);
    check("frame1_queue_empty", exp_q.size(), 0);
    check("frame1_busy_low", o_busy, 0);

    // Credits banked during prime: lines 4 and 5 follow with no gap.
    d0 = done_cnt;
    begin_frame();
    tick(5);
    pulse_intr();
    tick(5);
    pulse_intr();
    wait_xfers(48, 200, "banked_timeout");
    check("banked_no_gap", xfer_cyc[47] - xfer_cyc[31], 16);
    intr_burst(2, 4);
    wait_done(d0 + 1, 300, "frame2_done_timeout");
    tick(3);
    check("frame2_total", xfer_cnt, FRAME_PIX);
    check("frame2_queue_empty", exp_q.size(), 0);

    // Random back-pressure; extra pulses exercise credit saturation.
    d0 = done_cnt;
    rand_ready = 1'b1;
    begin_frame();
    intr_burst(6, $urandom_range(3, 30));
    wait_done(d0 + 1, 3000, "frame3_done_timeout");
    rand_ready = 1'b0;
    tick(3);
    check("frame3_total", xfer_cnt, FRAME_PIX);
    check("frame3_done_once", done_cnt, d0 + 1);
    check("frame3_queue_empty", exp_q.size(), 0);

    // Abort mid-prime, then a clean restart from pixel 0.
    d0 = done_cnt;
    begin_frame();
    wait_xfers(13, 100, "abort_wait_timeout");
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid_low", o_data_valid, 0);
    check("abort_busy_low", o_busy, 0);
    tick(10);
    check("abort_no_done", done_cnt, d0);
    begin_frame();
    intr_burst(4, IMG_W);
    wait_done(d0 + 1, 400, "frame4_done_timeout");
    tick(3);
    check("frame4_total", xfer_cnt, FRAME_PIX);
    check("frame4_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a credited line.
    d0 = done_cnt;
    begin_frame();
    wait_xfers(32, 200, "pre_reset_timeout");
    pulse_intr();
    wait_xfers(36, 100, "mid_line_timeout");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("areset_valid", o_data_valid, 0);
    check("areset_busy", o_busy, 0);
    check("areset_done", o_done, 0);
    check("areset_rd_en", o_rd_en, 0);
    check("areset_data", o_data, 0);
    check("areset_addr", o_rd_addr, 0);
    tick(3);
    #2;
    rst_n = 1'b1;
    tick(2);
    begin_frame();
    wait_xfers(32, 200, "post_reset_timeout");
    tick(10);
    @(negedge clk);
    check("post_reset_count", xfer_cnt, 32);
    check("post_reset_valid_low", o_data_valid, 0);
    intr_burst(4, IMG_W + 2);
    wait_done(d0 + 1, 300, "frame5_done_timeout");
    tick(3);
    check("frame5_total", xfer_cnt, FRAME_PIX);
    check("frame5_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
